vld_packer: RTL



---
 rtl/core_pkg.sv | 23 ++
 rtl/vld_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the vector load path.
// Holds the VRF word type, vector length type, lane count and the packer FSM states.
// Pure declarations: no logic, no latency, no flow control.
package core_pkg;

    // Number of VRF lanes; a load block is always a whole multiple of this many words.
    localparam int unsigned NrLane = 4;

    // One VRF word as seen by the vector load unit.
    typedef logic [63:0] vrf_data_t;

    // Byte count of a vector operation.
    typedef logic [15:0] vlen_t;

    localparam int unsigned VrfWordB = $bits(vrf_data_t) / 8;

    typedef enum logic [1:0] {
        VLP_IDLE = 2'd0,
        VLP_FILL = 2'd1,
        VLP_PAD  = 2'd2
    } vld_packer_state_e;

endpackage : core_pkg

// File: rtl/vld_packer.sv
// Packs narrow memory-response beats little-endian into VRF words and pads
// each command with zero words up to a whole multiple of NrLane words.
// Latency: a completed word is on load_op_o the cycle after its last beat;
// done_o pulses the cycle after the command's final word is registered.
// Backpressure: a single output register; beats and pad words advance only
// when that register is empty or draining this cycle.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o/cmd_vlB_i load command (payload byte count)
//   mem_valid_i/mem_ready_o/mem_data_i memory beats, byte 0 = lowest address
//   load_op_valid_o/load_op_ready_i/load_op_o packed word stream to the VLU
//   done_o                            end-of-command pulse
// MemBytes must be a power of two that divides VrfWordB.
module vld_packer
    import core_pkg::*;
#(
    parameter int unsigned MemBytes = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  vlen_t                 cmd_vlB_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [8*MemBytes-1:0] mem_data_i,
    output logic                  load_op_valid_o,
    input  logic                  load_op_ready_i,
    output vrf_data_t             load_op_o,
    output logic                  done_o
);

    localparam int unsigned PtrW  = $clog2(VrfWordB);
    localparam int unsigned WcntW = $clog2(NrLane);

    vld_packer_state_e r_state_q;
    vlen_t             r_rem_q;
    logic [PtrW-1:0]   r_ptr_q;
    logic [WcntW-1:0]  r_wcnt_q;
    vrf_data_t         r_acc_q;
    vrf_data_t         r_out_q;
    logic              r_out_valid_q;
    logic              r_done_q;

    logic              w_slot;
    logic              w_beat;
    vrf_data_t         w_merged;
    vlen_t             w_rem_d;
    logic [PtrW-1:0]   w_ptr_d;
    logic              w_word_end;
    logic [WcntW-1:0]  w_wcnt_inc;

    // Output register can take a new word if empty or emptying this cycle.
    assign w_slot = !r_out_valid_q || load_op_ready_i;
    assign w_beat = (r_state_q == VLP_FILL) && mem_valid_i && w_slot;

    assign cmd_ready_o     = (r_state_q == VLP_IDLE);
    assign mem_ready_o     = (r_state_q == VLP_FILL) && w_slot;
    assign load_op_valid_o = r_out_valid_q;
    assign load_op_o       = r_out_q;
    assign done_o          = r_done_q;

    // Beat bytes beyond the remaining payload are zeroed so the tail word
    // never carries stale or out-of-command data.
    always_comb begin
        w_merged = r_acc_q;
        for (int k = 0; k < int'(MemBytes); k++) begin
            if (vlen_t'(k) < r_rem_q) begin
                w_merged[(int'(r_ptr_q) + k)*8 +: 8] = mem_data_i[k*8 +: 8];
            end else begin
                w_merged[(int'(r_ptr_q) + k)*8 +: 8] = 8'h00;
            end
        end
    end

    assign w_rem_d    = (r_rem_q > vlen_t'(MemBytes)) ? (r_rem_q - vlen_t'(MemBytes)) : '0;
    assign w_ptr_d    = r_ptr_q + PtrW'(MemBytes);
    assign w_word_end = ((int'(r_ptr_q) + int'(MemBytes)) == int'(VrfWordB)) || (w_rem_d == '0);
    assign w_wcnt_inc = r_wcnt_q + WcntW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= VLP_IDLE;
            r_rem_q       <= '0;
            r_ptr_q       <= '0;
            r_wcnt_q      <= '0;
            r_acc_q       <= '0;
            r_out_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_done_q <= 1'b0;

            // Drain; a load below in the same cycle overrides this (no bubble).
            if (r_out_valid_q && load_op_ready_i) begin
                r_out_valid_q <= 1'b0;
            end

            case (r_state_q)
                VLP_IDLE: begin
                    if (cmd_valid_i) begin
                        r_rem_q <= cmd_vlB_i;
                        r_ptr_q <= '0;
                        r_acc_q <= '0;
                        if (cmd_vlB_i == '0) begin
                            r_done_q <= 1'b1;
                        end else begin
                            r_state_q <= VLP_FILL;
                        end
                    end
                end

                VLP_FILL: begin
                    if (w_beat) begin
                        r_rem_q <= w_rem_d;
                        if (w_word_end) begin
                            r_out_q       <= w_merged;
                            r_out_valid_q <= 1'b1;
                            r_acc_q       <= '0;
                            r_ptr_q       <= '0;
                            r_wcnt_q      <= w_wcnt_inc;
                            if (w_rem_d == '0) begin
                                if (w_wcnt_inc == '0) begin
                                    r_state_q <= VLP_IDLE;
                                    r_done_q  <= 1'b1;
                                end else begin
                                    r_state_q <= VLP_PAD;
                                end
                            end
                        end else begin
                            r_acc_q <= w_merged;
                            r_ptr_q <= w_ptr_d;
                        end
                    end
                end

                VLP_PAD: begin
                    if (w_slot) begin
                        r_out_q       <= '0;
                        r_out_valid_q <= 1'b1;
                        r_wcnt_q      <= w_wcnt_inc;
                        if (w_wcnt_inc == '0) begin
                            r_state_q <= VLP_IDLE;
                            r_done_q  <= 1'b1;
                        end
                    end
                end

                default: r_state_q <= VLP_IDLE;
            endcase
        end
    end

endmodule : vld_packer
